cache_fill_fsm: RTL and testbench
=================================

CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 The block SHALL have parameter BLOCK_WORDS, default 8, meaning 16-bit words per cache block (power of two).
REQ-002 The block SHALL have parameter ADDR_W, default 16, meaning byte-address width.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port miss_detected  input  1  cache lookup missed this cycle.
REQ-006 Port miss_address  input  ADDR_W  byte address of the missing access.
REQ-007 Port fsm_busy  output  1  fill in progress; the pipeline stalls on it.
REQ-008 Port memory_read  output  1  read request to main memory this cycle.
REQ-009 Port memory_address  output  ADDR_W  byte address of the current request.
REQ-010 Port memory_data_valid  input  1  memory returns one word this cycle.
REQ-011 Port memory_data  input  16  returned word.
REQ-012 Port write_data_array  output  1  write fill_data into the data array this cycle.
REQ-013 Port fill_data  output  16  word to write; equals memory_data.
REQ-014 Port fill_word  output  log2(BLOCK_WORDS)  word offset within the block for fill_data.
REQ-015 Port write_tag_array  output  1  write tag/valid for the filled block this cycle.

Function
REQ-016 The block SHALL implement two states: IDLE and FILL.
REQ-017 In IDLE, miss_detected=1 at a rising edge SHALL latch the block base (miss_address with the low log2(BLOCK_WORDS)+1 bits cleared) and start offset, clear both counters, and enter FILL.
REQ-018 fsm_busy SHALL equal (state==FILL), becoming 1 the cycle after the miss is sampled.
REQ-019 In FILL, memory_read SHALL be 1 while issue count < BLOCK_WORDS; the issue count SHALL increment each such cycle (one request per cycle, no backpressure).
REQ-020 memory_address SHALL be base + 2*((start + issue count) mod BLOCK_WORDS).
REQ-021 write_data_array SHALL be memory_data_valid AND FILL AND receive count < BLOCK_WORDS, combinationally.
REQ-022 fill_word SHALL be (start + receive count) mod BLOCK_WORDS; returned words are assumed in request order.
REQ-023 The receive count SHALL increment on each accepted valid.
REQ-024 write_tag_array SHALL be 1 combinationally in the cycle the BLOCK_WORDS-th word is accepted; the FSM SHALL return to IDLE at that edge.
REQ-025 memory_data_valid in IDLE, or beyond BLOCK_WORDS in FILL, SHALL be ignored with no array writes.
REQ-026 miss_detected while in FILL SHALL be ignored; a miss present in the first IDLE cycle after a fill SHALL start a new fill.
REQ-027 Counters SHALL be log2(BLOCK_WORDS)+1 bits wide so the count BLOCK_WORDS is representable without wrap.
REQ-028 Outside FILL, memory_read, write_data_array and write_tag_array SHALL be 0; memory_address and fill_word are don't-care but SHALL be driven.

Reset
REQ-029 rst_n=0 SHALL asynchronously force IDLE, clear the counters, base and start, and drive fsm_busy, memory_read, write_data_array and write_tag_array to 0.
REQ-030 Reset asserted mid-fill SHALL abandon the fill without asserting write_tag_array; late memory valids after release SHALL be ignored (REQ-025).

Configuration
REQ-031 With CACHE_FILL_CRITICAL_WORD_FIRST_EN defined, start SHALL be miss_address[log2(BLOCK_WORDS):1], and requests wrap modulo BLOCK_WORDS.
REQ-032 Without CACHE_FILL_CRITICAL_WORD_FIRST_EN, start SHALL be 0, so requests run from base upward.

Verification
REQ-033 Macro off: miss at 0x1236, memory returns a valid 4 cycles after each read -> addresses 0x1230..0x123E in order, 8 data writes with fill_word 0..7, one write_tag_array, fsm_busy high 12 cycles.
REQ-034 Macro on: miss at 0x1236 -> addresses 0x1236,0x1238,0x123A,0x123C,0x123E,0x1230,0x1232,0x1234; fill_word 3,4,5,6,7,0,1,2.
REQ-035 miss_detected held high throughout a fill of 0x0040 -> a single fill; a new fill starts in the first IDLE cycle after write_tag_array.
REQ-036 rst_n pulsed low after the 3rd valid of a fill -> immediate IDLE, no write_tag_array; 5 trailing valids -> no write_data_array.
REQ-037 Spurious memory_data_valid=1 in IDLE with data 0xBEEF -> write_data_array stays 0.
REQ-038 Back-to-back misses at 0xFFF0 and 0x0000 -> addresses stay within each block, no carry across 0xFFFE.

Source files
------------

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: fetches one cache block from main memory after a lookup miss.
// Issues one word request per cycle (no backpressure) and writes each returned
// word into the data array; the last returned word also writes the tag/valid
// entry, and the FSM then returns to IDLE.
//
// Optional feature macro: CACHE_FILL_CRITICAL_WORD_FIRST_EN
//   defined   -> requests start at the missing word and wrap within the block
//   undefined -> requests run from the block base upward
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   miss_detected      lookup missed this cycle (sampled only in IDLE)
//   miss_address       byte address of the missing access
//   fsm_busy           fill in progress (pipeline stall)
//   memory_read        word read request this cycle
//   memory_address     byte address of the current request
//   memory_data_valid  memory returns one word this cycle (in request order)
//   memory_data        returned word
//   write_data_array   write fill_data at fill_word this cycle
//   fill_data          word to write (memory_data passed through)
//   fill_word          word offset within the block for fill_data
//   write_tag_array    write tag/valid for the filled block this cycle
module cache_fill_fsm #(
  parameter int unsigned BLOCK_WORDS = 8,
  parameter int unsigned ADDR_W      = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           miss_detected,
  input  logic [ADDR_W-1:0]              miss_address,
  output logic                           fsm_busy,
  output logic                           memory_read,
  output logic [ADDR_W-1:0]              memory_address,
  input  logic                           memory_data_valid,
  input  logic [15:0]                    memory_data,
  output logic                           write_data_array,
  output logic [15:0]                    fill_data,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
  output logic                           write_tag_array
);

  localparam int unsigned OFF_W  = $clog2(BLOCK_WORDS);
  localparam int unsigned CNT_W  = OFF_W + 1;
  localparam int unsigned LINE_W = OFF_W + 1;

  // Byte-offset bits of a block; cleared to form the block base.
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'((1 << LINE_W) - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(BLOCK_WORDS);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BLOCK_WORDS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [OFF_W-1:0]  start;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  recv_cnt;

  logic              in_fill;
  logic [OFF_W-1:0]  miss_start;
  logic [OFF_W-1:0]  issue_idx;

  // Word offset at which a newly detected miss begins fetching.
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  assign miss_start = miss_address[OFF_W:1];
`else
  assign miss_start = '0;
`endif

  // Decode of the registered state and counters.
  assign in_fill  = (state == FILL);
  assign fsm_busy = in_fill;

  assign memory_read = in_fill && (issue_cnt < CNT_FULL);

  // Offsets wrap naturally in OFF_W bits (mod BLOCK_WORDS).
  assign issue_idx = start + issue_cnt[OFF_W-1:0];

  // base has its line bits cleared, so OR-ing the offset never carries out of the block.
  assign memory_address = base | ADDR_W'({issue_idx, 1'b0});

  assign write_data_array = in_fill && memory_data_valid && (recv_cnt < CNT_FULL);
  assign fill_word        = start + recv_cnt[OFF_W-1:0];
  assign fill_data        = memory_data;
  assign write_tag_array  = write_data_array && (recv_cnt == CNT_LAST);

  // State, latched miss context and request/return counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      base      <= '0;
      start     <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_detected) begin
            base      <= miss_address & ~LINE_MASK;
            start     <= miss_start;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            state     <= FILL;
          end
        end
        FILL: begin
          if (memory_read) begin
            issue_cnt <= issue_cnt + CNT_W'(1);
          end
          if (write_data_array) begin
            recv_cnt <= recv_cnt + CNT_W'(1);
          end
          if (write_tag_array) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm. A queue-based model predicts the
// request address stream and the returned-word offsets for each fill; a
// memory responder answers every read in order after a random latency.
`timescale 1ns/1ps
module tb_cache_fill_fsm;

  localparam int BW = 8;
  localparam int AW = 16;
  localparam int OW = $clog2(BW);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          miss_detected;
  logic [AW-1:0] miss_address;
  logic          fsm_busy;
  logic          memory_read;
  logic [AW-1:0] memory_address;
  logic          memory_data_valid;
  logic [15:0]   memory_data;
  logic          write_data_array;
  logic [15:0]   fill_data;
  logic [OW-1:0] fill_word;
  logic          write_tag_array;

  cache_fill_fsm #(.BLOCK_WORDS(BW), .ADDR_W(AW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .miss_detected    (miss_detected),
    .miss_address     (miss_address),
    .fsm_busy         (fsm_busy),
    .memory_read      (memory_read),
    .memory_address   (memory_address),
    .memory_data_valid(memory_data_valid),
    .memory_data      (memory_data),
    .write_data_array (write_data_array),
    .fill_data        (fill_data),
    .fill_word        (fill_word),
    .write_tag_array  (write_tag_array)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model: remaining request addresses and remaining word offsets of the fill.
  logic [AW-1:0] exp_addr[$];
  logic [OW-1:0] exp_word[$];
  // Responder: cycle numbers at which a valid word is returned.
  int due_q[$];
  int last_due = 0;

  logic          drv_rst   = 1'b0;
  logic          drv_miss  = 1'b0;
  logic          drv_spur  = 1'b0;
  logic [AW-1:0] drv_addr  = '0;
  int            lat_fixed = 4;

  logic [AW-1:0] addr_log[$];
  logic [OW-1:0] word_log[$];
  int tag_cnt, busy_cnt, wr_cnt, vld_cnt;

  logic [AW-1:0] lit_addr[8];
  logic [OW-1:0] lit_word[8];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", nm, act, exp, cyc);
    end
  endfunction

  function automatic void build(logic [AW-1:0] a);
    int ai, base, st;
    ai   = int'(a);
    base = ai - (ai % (2 * BW));
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    st = (ai / 2) % BW;
`else
    st = 0;
`endif
    exp_addr.delete();
    exp_word.delete();
    for (int i = 0; i < BW; i++) begin
      exp_addr.push_back(AW'(base + 2 * ((st + i) % BW)));
      exp_word.push_back(OW'((st + i) % BW));
    end
  endfunction

  task automatic clear_logs();
    addr_log.delete();
    word_log.delete();
    tag_cnt = 0; busy_cnt = 0; wr_cnt = 0; vld_cnt = 0;
  endtask

  // One cycle: drive inputs after negedge, compare, then advance the model.
  task automatic step();
    logic        rv;
    logic [15:0] rd;
    logic        exp_busy, exp_rd, exp_wr, exp_tag;
    int          d;
    @(negedge clk);
    cyc++;
    rst_n         = drv_rst;
    miss_detected = drv_miss;
    miss_address  = drv_addr;
    rv = 1'b0;
    rd = 16'($urandom);
    if (due_q.size() != 0 && due_q[0] == cyc) begin
      rv = 1'b1;
      void'(due_q.pop_front());
    end else if (drv_spur && exp_word.size() == 0) begin
      rv = 1'b1;
      rd = 16'hBEEF;
    end
    memory_data_valid = rv;
    memory_data       = rd;
    if (!drv_rst) begin
      exp_addr.delete();
      exp_word.delete();
    end
    #1;
    exp_busy = (exp_word.size() != 0);
    exp_rd   = exp_busy && (exp_addr.size() != 0);
    exp_wr   = exp_busy && rv;
    exp_tag  = exp_wr && (exp_word.size() == 1);
    chk("fsm_busy", 32'(fsm_busy), 32'(exp_busy));
    chk("memory_read", 32'(memory_read), 32'(exp_rd));
    chk("write_data_array", 32'(write_data_array), 32'(exp_wr));
    chk("write_tag_array", 32'(write_tag_array), 32'(exp_tag));
    if (exp_rd) chk("memory_address", 32'(memory_address), 32'(exp_addr[0]));
    if (exp_wr) begin
      chk("fill_word", 32'(fill_word), 32'(exp_word[0]));
      chk("fill_data", 32'(fill_data), 32'(rd));
    end
    if (memory_read) addr_log.push_back(memory_address);
    if (write_data_array) begin
      word_log.push_back(fill_word);
      wr_cnt++;
    end
    if (write_tag_array) tag_cnt++;
    if (fsm_busy) busy_cnt++;
    if (rv) vld_cnt++;
    if (drv_rst) begin
      if (exp_busy) begin
        if (exp_rd) begin
          d = cyc + ((lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 6)));
          if (d <= last_due) d = last_due + 1;
          last_due = d;
          due_q.push_back(d);
          void'(exp_addr.pop_front());
        end
        if (exp_wr) void'(exp_word.pop_front());
      end else if (drv_miss) begin
        build(drv_addr);
      end
    end
  endtask

  task automatic wait_idle(int max, string nm);
    int n = 0;
    while ((exp_word.size() != 0 || due_q.size() != 0) && n < max) begin
      step();
      n++;
    end
    checks++;
    if (exp_word.size() != 0 || due_q.size() != 0) begin
      failures++;
      $display("FAIL %s actual=timeout expected=idle within %0d cycles", nm, max);
    end
  endtask

  task automatic run_until_tags(int target, int max, string nm);
    int n = 0;
    while (tag_cnt < target && n < max) begin
      step();
      n++;
    end
    chk(nm, 32'(tag_cnt), 32'(target));
  endtask

  initial begin
    int n, gap;
    logic seen;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    lit_addr = '{16'h1236, 16'h1238, 16'h123A, 16'h123C, 16'h123E, 16'h1230, 16'h1232, 16'h1234};
    lit_word = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
`else
    lit_addr = '{16'h1230, 16'h1232, 16'h1234, 16'h1236, 16'h1238, 16'h123A, 16'h123C, 16'h123E};
    lit_word = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
`endif
    rst_n = 1'b0; miss_detected = 1'b0; miss_address = '0;
    memory_data_valid = 1'b0; memory_data = '0;
    clear_logs();

    // Reset state.
    drv_rst = 1'b0;
    repeat (3) step();
    drv_rst = 1'b1;
    step();

    // Single fill of 0x1236 with a fixed 4-cycle memory latency.
    lat_fixed = 4;
    clear_logs();
    drv_miss = 1'b1; drv_addr = 16'h1236;
    step();
    drv_miss = 1'b0;
    chk("model_len", 32'(exp_addr.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < exp_addr.size()) chk("model_addr", 32'(exp_addr[i]), 32'(lit_addr[i]));
    wait_idle(40, "fill1_timeout");
    repeat (2) step();
    chk("fill1_reads", 32'(addr_log.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < addr_log.size()) chk("fill1_addr", 32'(addr_log[i]), 32'(lit_addr[i]));
    chk("fill1_writes", 32'(word_log.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < word_log.size()) chk("fill1_word", 32'(word_log[i]), 32'(lit_word[i]));
    chk("fill1_tags", 32'(tag_cnt), 32'd1);
    chk("fill1_busy_cycles", 32'(busy_cnt), 32'd12);

    // Miss held high across a fill: exactly one idle cycle between fills.
    lat_fixed = 0;
    clear_logs();
    drv_miss = 1'b1; drv_addr = 16'h0040;
    n = 0; gap = 0; seen = 1'b0;
    while (tag_cnt < 2 && n < 80) begin
      step();
      n++;
      if (fsm_busy) seen = 1'b1;
      else if (seen && tag_cnt < 2) gap++;
    end
    drv_miss = 1'b0;
    wait_idle(60, "hold_timeout");
    chk("hold_tags", 32'(tag_cnt), 32'd2);
    chk("hold_idle_gap", 32'(gap), 32'd1);
    chk("hold_reads", 32'(addr_log.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      if (i < addr_log.size()) chk("hold_addr", 32'(addr_log[i]), 32'(16'h0040 + 2 * (i % 8)));

    // Reset after the third returned word abandons the fill.
    lat_fixed = 4;
    drv_miss = 1'b1; drv_addr = 16'h1236;
    step();
    drv_miss = 1'b0;
    n = 0;
    while (exp_word.size() > BW - 3 && n < 40) begin
      step();
      n++;
    end
    chk("rst_third_word", 32'(exp_word.size()), 32'(BW - 3));
    clear_logs();
    drv_rst = 1'b0; drv_spur = 1'b1;
    step();
    drv_rst = 1'b1;
    repeat (12) step();
    drv_spur = 1'b0;
    chk("rst_tags", 32'(tag_cnt), 32'd0);
    chk("rst_writes", 32'(wr_cnt), 32'd0);
    chk("rst_busy", 32'(busy_cnt), 32'd0);
    chk("rst_trailing_valids", 32'(vld_cnt >= 5), 32'd1);
    wait_idle(40, "rst_drain_timeout");

    // Spurious valid with 0xBEEF while idle.
    clear_logs();
    drv_spur = 1'b1;
    repeat (6) step();
    drv_spur = 1'b0;
    chk("spur_valids", 32'(vld_cnt), 32'd6);
    chk("spur_writes", 32'(wr_cnt), 32'd0);
    chk("spur_busy", 32'(busy_cnt), 32'd0);

    // Back-to-back fills at the top and bottom of the address space.
    lat_fixed = 0;
    clear_logs();
    drv_miss = 1'b1; drv_addr = 16'hFFF0;
    step();
    drv_addr = 16'h0000;
    run_until_tags(2, 80, "wrap_tags");
    drv_miss = 1'b0;
    wait_idle(60, "wrap_timeout");
    chk("wrap_reads", 32'(addr_log.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      if (i < addr_log.size())
        chk("wrap_addr", 32'(addr_log[i]), (i < 8) ? 32'(16'hFFF0 + 2 * i) : 32'(2 * (i - 8)));

    // Randomized traffic with occasional resets and spurious valids.
    lat_fixed = 0;
    for (int k = 0; k < 3000; k++) begin
      drv_miss = ($urandom_range(0, 3) == 0);
      drv_addr = AW'($urandom);
      drv_spur = ($urandom_range(0, 2) == 0);
      drv_rst  = ($urandom_range(0, 199) != 0);
      step();
    end
    drv_rst = 1'b1; drv_miss = 1'b0; drv_spur = 1'b0;
    wait_idle(200, "random_drain_timeout");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
